visualizador_hamming: RTL and testbench

- Downstream stage of the SECDED error-correction stage.
- Captures one decoded result per `dato_valido` pulse: corrected nibble, received data nibble, syndrome and error flags.
- Drives a 4-digit multiplexed common-anode 7-segment display and two status LEDs.
- The double-error LED blinks.

---
 rtl/visualizador_hamming.sv | 186 ++++++++++++++++++
 tb/tb_visualizador_hamming.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/visualizador_hamming.sv
// visualizador_hamming: display stage after the SECDED decoder.
// Latches one decoded result per dato_valido pulse and shows it on a 4-digit
// multiplexed common-anode 7-segment display, plus single/double error LEDs.
// D0 = corrected nibble, D1 = received data nibble, D2 = syndrome position,
// D3 = error count. Double errors blank D0/D1 with dashes and blink led_doble.
// Optional macro DP_INDICADOR_EN adds the active-low decimal point output
// `punto`, lit on D2 while a single error is captured.
module visualizador_hamming #(
    parameter int unsigned CICLOS_DIGITO   = 27000,
    parameter int unsigned CICLOS_PARPADEO = 6750000
) (
    input  logic       reloj,
    input  logic       rst_n,
    input  logic       dato_valido,
    input  logic [3:0] corregido,
    input  logic [7:0] recibido,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    input  logic       error_simple,
    input  logic       error_doble,
    output logic [3:0] anodos,
    output logic [6:0] segmentos,
    output logic       led_simple,
    output logic       led_doble
`ifdef DP_INDICADOR_EN
    ,
    output logic       punto
`endif
);

    localparam int unsigned DW = (CICLOS_DIGITO > 1) ? $clog2(CICLOS_DIGITO) : 1;
    localparam int unsigned BW = (CICLOS_PARPADEO > 1) ? $clog2(CICLOS_PARPADEO) : 1;
    localparam logic [DW-1:0] DIG_MAX   = DW'(CICLOS_DIGITO - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(CICLOS_PARPADEO - 1);
    localparam logic [6:0]    SEG_GUION = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a} hex glyphs.
    function automatic logic [6:0] hex_a_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [DW-1:0] dig_cnt_q, dig_cnt_d;
    logic [1:0]    scan_q, scan_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [3:0]    cap_corr_q, cap_corr_d;
    logic [3:0]    cap_rec_q, cap_rec_d;
    logic [2:0]    cap_pos_q, cap_pos_d;
    logic          cap_simple_q, cap_simple_d;
    logic          cap_doble_q, cap_doble_d;
    logic          capturado_q, capturado_d;
    logic          cap_stb_q, cap_stb_d;
    logic [3:0]    anodos_q, anodos_d;
    logic [6:0]    segmentos_q, segmentos_d;
    logic          led_simple_q, led_simple_d;
    logic          led_doble_q, led_doble_d;
    logic          punto_q, punto_d;

    // Received codeword bits that carry parity, not data.
    logic unused_bits;
    assign unused_bits = ^{recibido[7], recibido[3], recibido[1:0]};

    // Next-state: scan timing, capture, blink and registered display outputs.
    always_comb begin
        dig_cnt_d    = (dig_cnt_q == DIG_MAX) ? '0 : dig_cnt_q + DW'(1);
        scan_d       = (dig_cnt_q == DIG_MAX) ? scan_q + 2'd1 : scan_q;

        cap_corr_d   = cap_corr_q;
        cap_rec_d    = cap_rec_q;
        cap_pos_d    = cap_pos_q;
        cap_simple_d = cap_simple_q;
        cap_doble_d  = cap_doble_q;
        capturado_d  = capturado_q;
        cap_stb_d    = dato_valido;
        if (dato_valido) begin
            cap_corr_d   = corregido;
            cap_rec_d    = {recibido[6], recibido[5], recibido[4], recibido[2]};
            cap_pos_d    = {s3, s2, s1};
            // Double error wins when both flags are raised.
            cap_simple_d = error_simple & ~error_doble;
            cap_doble_d  = error_doble;
            capturado_d  = 1'b1;
        end

        led_simple_d = cap_simple_q;

        // Blink restarts on the edge after every capture.
        blink_cnt_d = '0;
        led_doble_d = 1'b0;
        if (cap_stb_q) begin
            led_doble_d = cap_doble_q;
        end else if (cap_doble_q) begin
            if (blink_cnt_q == BLINK_MAX) begin
                led_doble_d = ~led_doble_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                led_doble_d = led_doble_q;
            end
        end

        anodos_d    = ~(4'b0001 << scan_q);
        segmentos_d = SEG_GUION;
        punto_d     = 1'b1;
        if (capturado_q) begin
            unique case (scan_q)
                2'd0: segmentos_d = cap_doble_q ? SEG_GUION : hex_a_seg(cap_corr_q);
                2'd1: segmentos_d = cap_doble_q ? SEG_GUION : hex_a_seg(cap_rec_q);
                2'd2: begin
                    segmentos_d = hex_a_seg({1'b0, cap_pos_q});
                    punto_d     = ~cap_simple_q;
                end
                default: segmentos_d = hex_a_seg(cap_doble_q  ? 4'd2 :
                                                 cap_simple_q ? 4'd1 : 4'd0);
            endcase
        end
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge reloj) begin
        if (!rst_n) begin
            dig_cnt_q    <= '0;
            scan_q       <= 2'd0;
            blink_cnt_q  <= '0;
            cap_corr_q   <= 4'd0;
            cap_rec_q    <= 4'd0;
            cap_pos_q    <= 3'd0;
            cap_simple_q <= 1'b0;
            cap_doble_q  <= 1'b0;
            capturado_q  <= 1'b0;
            cap_stb_q    <= 1'b0;
            anodos_q     <= 4'b1111;
            segmentos_q  <= 7'b1111111;
            led_simple_q <= 1'b0;
            led_doble_q  <= 1'b0;
            punto_q      <= 1'b1;
        end else begin
            dig_cnt_q    <= dig_cnt_d;
            scan_q       <= scan_d;
            blink_cnt_q  <= blink_cnt_d;
            cap_corr_q   <= cap_corr_d;
            cap_rec_q    <= cap_rec_d;
            cap_pos_q    <= cap_pos_d;
            cap_simple_q <= cap_simple_d;
            cap_doble_q  <= cap_doble_d;
            capturado_q  <= capturado_d;
            cap_stb_q    <= cap_stb_d;
            anodos_q     <= anodos_d;
            segmentos_q  <= segmentos_d;
            led_simple_q <= led_simple_d;
            led_doble_q  <= led_doble_d;
            punto_q      <= punto_d;
        end
    end

    assign anodos     = anodos_q;
    assign segmentos  = segmentos_q;
    assign led_simple = led_simple_q;
    assign led_doble  = led_doble_q;

`ifdef DP_INDICADOR_EN
    assign punto = punto_q;
`else
    logic unused_punto;
    assign unused_punto = punto_q;
`endif

endmodule

// File: tb/tb_visualizador_hamming.sv
// Self-checking bench for visualizador_hamming (CICLOS_DIGITO=4, CICLOS_PARPADEO=8).
module tb_visualizador_hamming;

    localparam int unsigned CD = 4;
    localparam int unsigned CP = 8;
    localparam logic [6:0] GUION = 7'b0111111;

    logic       reloj = 1'b0;
    logic       rst_n = 1'b0;
    logic       dato_valido = 1'b0;
    logic [3:0] corregido = 4'd0;
    logic [7:0] recibido = 8'd0;
    logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic       error_simple = 1'b0, error_doble = 1'b0;
    logic [3:0] anodos;
    logic [6:0] segmentos;
    logic       led_simple, led_doble;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int         digito;
        logic [6:0] seg;
    } esperado_t;
    esperado_t sb_q[$];

    visualizador_hamming #(
        .CICLOS_DIGITO  (CD),
        .CICLOS_PARPADEO(CP)
    ) dut (
        .reloj       (reloj),
        .rst_n       (rst_n),
        .dato_valido (dato_valido),
        .corregido   (corregido),
        .recibido    (recibido),
        .s1          (s1),
        .s2          (s2),
        .s3          (s3),
        .error_simple(error_simple),
        .error_doble (error_doble),
        .anodos      (anodos),
        .segmentos   (segmentos),
        .led_simple  (led_simple),
        .led_doble   (led_doble)
    );

    always #5 reloj = ~reloj;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
    endfunction

    // Drive one capture pulse; returns just after the capture edge.
    task automatic pulso(input logic [3:0] c, input logic [7:0] r, input logic [2:0] s,
                         input logic es, input logic ed);
        corregido    = c;
        recibido     = r;
        s3           = s[2];
        s2           = s[1];
        s1           = s[0];
        error_simple = es;
        error_doble  = ed;
        dato_valido  = 1'b1;
        tick();
        dato_valido  = 1'b0;
    endtask

    // Scoreboard push: expected glyph for every digit after a capture.
    task automatic esperar_captura(input logic [3:0] c, input logic [7:0] r,
                                   input logic [2:0] s, input logic es, input logic ed);
        logic [3:0] rn;
        logic [3:0] cuenta;
        rn     = {r[6], r[5], r[4], r[2]};
        cuenta = ed ? 4'd2 : (es ? 4'd1 : 4'd0);
        sb_q.push_back('{0, ed ? GUION : seg_ref(c)});
        sb_q.push_back('{1, ed ? GUION : seg_ref(rn)});
        sb_q.push_back('{2, seg_ref({1'b0, s})});
        sb_q.push_back('{3, seg_ref(cuenta)});
    endtask

    // Scoreboard pop: wait for each digit to be scanned and compare its glyph.
    task automatic revisar_display(input string nombre);
        esperado_t e;
        logic [3:0] an_exp;
        int espera;
        while (sb_q.size() > 0) begin
            e      = sb_q.pop_front();
            an_exp = ~(4'b0001 << e.digito);
            espera = 0;
            while (anodos !== an_exp && espera < 24) begin
                tick();
                espera++;
            end
            tests_run++;
            if (anodos !== an_exp) begin
                tests_failed++;
                $display("FAIL %s D%0d scan timeout: anodos got %b required %b",
                         nombre, e.digito, anodos, an_exp);
            end else if (segmentos !== e.seg) begin
                tests_failed++;
                $display("FAIL %s D%0d: segmentos got %b required %b",
                         nombre, e.digito, segmentos, e.seg);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] an_exp;
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if (anodos !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset anodos: got %b required 1111", anodos);
        end
        tests_run++;
        if (segmentos !== 7'b1111111) begin
            tests_failed++;
            $display("FAIL reset segmentos: got %b required 1111111", segmentos);
        end
        tests_run++;
        if ({led_simple, led_doble} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset leds: got %b required 00", {led_simple, led_doble});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            an_exp = ~(4'b0001 << ((k / CD) % 4));
            tests_run++;
            if (anodos !== an_exp || segmentos !== GUION || {led_simple, led_doble} !== 2'b00)
            begin
                tests_failed++;
                $display("FAIL idle scan cycle %0d: got an=%b seg=%b leds=%b required an=%b seg=%b leds=00",
                         k, anodos, segmentos, {led_simple, led_doble}, an_exp, GUION);
            end
        end
    endtask

    task automatic test_sin_error();
        pulso(4'hA, 8'h24, 3'b000, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (led_simple !== 1'b0) begin
            tests_failed++;
            $display("FAIL sin_error led_simple: got %b required 0", led_simple);
        end
        esperar_captura(4'hA, 8'h24, 3'b000, 1'b0, 1'b0);
        revisar_display("sin_error");
    endtask

    task automatic test_error_simple();
        pulso(4'h3, 8'hFF, 3'b011, 1'b1, 1'b0);
        tests_run++;
        if (led_simple !== 1'b0) begin
            tests_failed++;
            $display("FAIL simple led_simple at capture edge: got %b required 0", led_simple);
        end
        tick();
        tests_run++;
        if (led_simple !== 1'b1 || led_doble !== 1'b0) begin
            tests_failed++;
            $display("FAIL simple leds after capture: got %b%b required 10", led_simple, led_doble);
        end
        esperar_captura(4'h3, 8'hFF, 3'b011, 1'b1, 1'b0);
        revisar_display("error_simple");
    endtask

    task automatic test_error_doble();
        logic esp;
        pulso(4'h9, 8'h5A, 3'b101, 1'b1, 1'b1);
        tests_run++;
        if (led_doble !== 1'b0) begin
            tests_failed++;
            $display("FAIL doble led_doble at capture edge: got %b required 0", led_doble);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            esp = (((k - 1) / CP) % 2 == 0);
            tests_run++;
            if (led_doble !== esp) begin
                tests_failed++;
                $display("FAIL doble blink k=%0d: got %b required %b", k, led_doble, esp);
            end
            if (k == 1) begin
                tests_run++;
                if (led_simple !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL doble priority led_simple: got %b required 0", led_simple);
                end
            end
        end
        esperar_captura(4'h9, 8'h5A, 3'b101, 1'b1, 1'b1);
        revisar_display("error_doble");
        pulso(4'h2, 8'h00, 3'b000, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            tests_run++;
            if (led_doble !== 1'b0) begin
                tests_failed++;
                $display("FAIL doble cleared by clean capture k=%0d: got %b required 0",
                         k, led_doble);
            end
        end
    endtask

    task automatic test_reset_intermedio();
        logic [3:0] an_exp;
        pulso(4'h6, 8'h10, 3'b110, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++;
        if (anodos !== 4'b1111 || segmentos !== 7'b1111111 ||
            {led_simple, led_doble} !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid reset outputs: got an=%b seg=%b leds=%b required 1111 1111111 00",
                     anodos, segmentos, {led_simple, led_doble});
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            an_exp = ~(4'b0001 << ((k / CD) % 4));
            tests_run++;
            if (anodos !== an_exp || segmentos !== GUION || led_doble !== 1'b0) begin
                tests_failed++;
                $display("FAIL after mid reset k=%0d: got an=%b seg=%b ld=%b required an=%b seg=%b ld=0",
                         k, anodos, segmentos, led_doble, an_exp, GUION);
            end
        end
    endtask

    task automatic test_back_to_back();
        int espera;
        pulso(4'h1, 8'h00, 3'b000, 1'b0, 1'b0);
        espera = 0;
        while (anodos !== 4'b1011 && espera < 40) begin
            tick();
            espera++;
        end
        while (anodos !== 4'b0111 && espera < 40) begin
            tick();
            espera++;
        end
        tests_run++;
        if (anodos !== 4'b0111) begin
            tests_failed++;
            $display("FAIL wrap sync timeout: anodos got %b required 0111", anodos);
            return;
        end
        // Two more cycles put the digit counter on its last count in D3.
        tick();
        tick();
        pulso(4'h7, 8'h00, 3'b000, 1'b0, 1'b0);
        tests_run++;
        if (anodos !== 4'b0111) begin
            tests_failed++;
            $display("FAIL wrap capture edge anodos: got %b required 0111", anodos);
        end
        sb_q.push_back('{0, seg_ref(4'h7)});
        tick();
        tests_run++;
        if (anodos !== 4'b1110 || segmentos !== sb_q[0].seg) begin
            tests_failed++;
            $display("FAIL wrap D0 new value: got an=%b seg=%b required an=1110 seg=%b",
                     anodos, segmentos, sb_q[0].seg);
        end
        void'(sb_q.pop_front());
        for (int k = 1; k < CD; k++) begin
            tick();
            tests_run++;
            if (anodos !== 4'b1110) begin
                tests_failed++;
                $display("FAIL wrap D0 hold k=%0d: got %b required 1110", k, anodos);
            end
        end
        tick();
        tests_run++;
        if (anodos !== 4'b1101) begin
            tests_failed++;
            $display("FAIL wrap period: anodos got %b required 1101", anodos);
        end
    endtask

    initial begin
        test_reset();
        test_sin_error();
        test_error_simple();
        test_error_doble();
        test_reset_intermedio();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
